dht11_display: RTL and testbench

Consumes the 8-bit temperature and humidity bytes produced by the DHT11 decoder and shows them on the board's three-digit multiplexed seven-segment display. It alternates between `t` + temperature and `H` + humidity. Each byte is converted to BCD with a serial double-dabble engine, and the digits are time-multiplexed at a fixed refresh rate. It sits directly downstream of the decoder and drives the display pins through the top level.

---
 rtl/dht11_pkg.sv | 45 ++++
 rtl/dht11_display_bin2bcd_serial.sv | 66 ++++++
 rtl/dht11_display.sv | 135 +++++++++++++
 tb/tb_dht11_display.sv | 134 +++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// Shared constants for the DHT11 seven-segment display path: segment codes,
// converter state encoding and digit slot indices.
package dht11_pkg;

    // Active-low segments, {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_T     = 8'h87;
    localparam logic [7:0] SEG_H     = 8'h89;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {ConvIdle, ConvShift, ConvDone} conv_state_e;

    localparam logic [1:0] DIG_LEFT  = 2'd2;
    localparam logic [1:0] DIG_MID   = 2'd1;
    localparam logic [1:0] DIG_RIGHT = 2'd0;

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dht11_display_bin2bcd_serial.sv
// Serial double-dabble: 8-bit binary to three BCD nibbles in 8 shift cycles,
// bracketed by one load cycle and one done cycle.
module bin2bcd_serial
    import dht11_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    conv_state_e state_q, state_d;
    logic [19:0] sr_q, sr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [19:0] adj;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        adj     = sr_q;
        for (int i = 0; i < 3; i++) begin
            if (sr_q[8 + 4*i +: 4] >= 4'd5) begin
                adj[8 + 4*i +: 4] = sr_q[8 + 4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            ConvIdle: begin
                if (start) begin
                    sr_d    = {12'b0, bin};
                    cnt_d   = 3'd0;
                    state_d = ConvShift;
                end
            end
            ConvShift: begin
                sr_d  = {adj[18:0], 1'b0};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ConvDone;
                end
            end
            ConvDone: state_d = ConvIdle;
            default:  state_d = ConvIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ConvIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != ConvIdle);
    assign done = (state_q == ConvDone);
    assign bcd  = sr_q[19:8];

endmodule

// File: rtl/dht11_display.sv
// Alternating temperature / humidity readout on a 3-digit multiplexed
// seven-segment display; digits and mode letter are committed atomically.
module dht11_display
    import dht11_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 1000,
    parameter int unsigned ALT_TICKS   = 2000
) (
    input  logic       clk1mhz,
    input  logic       rst_n,
    input  logic [7:0] temp,
    input  logic [7:0] humidity,
    output logic [7:0] seg_n,
    output logic [2:0] digit_en_n,
    output logic       mode
);

    localparam int unsigned SlotW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned PhaseW = (ALT_TICKS > 1) ? $clog2(ALT_TICKS) : 1;

    logic [SlotW-1:0]  slot_q, slot_d;
    logic [PhaseW-1:0] phase_q, phase_d;
    logic              tick_q, tick_d;
    logic [1:0]        digit_idx_q, digit_idx_d;
    logic              pend_mode_q, pend_mode_d;
    logic              conv_start_q, conv_start_d;
    logic              valid_q, valid_d;
    logic [3:0]        hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic              mode_q, mode_d;
    logic [7:0]        seg_q, seg_d;
    logic [2:0]        en_q, en_d;

    logic              slot_wrap, phase_wrap;
    logic              conv_busy, conv_done;
    logic [11:0]       conv_bcd;
    logic [7:0]        seg_sel;

    bin2bcd_serial u_bin2bcd (
        .clk   (clk1mhz),
        .rst_n (rst_n),
        .start (conv_start_q & ~conv_busy),
        .bin   (pend_mode_q ? humidity : temp),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        seg_sel = SEG_BLANK;
        if (valid_q) begin
            case (digit_idx_q)
                DIG_LEFT:  seg_sel = mode_q ? SEG_H : SEG_T;
                DIG_MID:   seg_sel = (hund_q != 4'd0) ? SEG_DASH :
                                     (tens_q == 4'd0) ? SEG_BLANK : seg_digit(tens_q);
                DIG_RIGHT: seg_sel = (hund_q != 4'd0) ? SEG_DASH : seg_digit(ones_q);
                default:   seg_sel = SEG_BLANK;
            endcase
        end
    end

    always_comb begin
        slot_d       = slot_q;
        phase_d      = phase_q;
        digit_idx_d  = digit_idx_q;
        pend_mode_d  = pend_mode_q;
        valid_d      = valid_q;
        hund_d       = hund_q;
        tens_d       = tens_q;
        ones_d       = ones_q;
        mode_d       = mode_q;
        seg_d        = seg_q;
        en_d         = en_q;

        slot_wrap    = (slot_q == SlotW'(REFRESH_DIV - 1));
        slot_d       = slot_wrap ? '0 : slot_q + 1'b1;
        tick_d       = slot_wrap;
        phase_wrap   = tick_q && (phase_q == PhaseW'(ALT_TICKS - 1));
        conv_start_d = phase_wrap;

        if (tick_q) begin
            phase_d     = phase_wrap ? '0 : phase_q + 1'b1;
            digit_idx_d = (digit_idx_q == DIG_RIGHT) ? DIG_LEFT : digit_idx_q - 2'd1;
            seg_d       = seg_sel;
            en_d        = ~(3'b001 << digit_idx_q);
        end
        // Toggled here so the sampling cycle already sees the new phase's mode
        if (phase_wrap) begin
            pend_mode_d = ~pend_mode_q;
        end
        if (conv_done) begin
            valid_d = 1'b1;
            hund_d  = conv_bcd[11:8];
            tens_d  = conv_bcd[7:4];
            ones_d  = conv_bcd[3:0];
            mode_d  = pend_mode_q;
        end
    end

    always_ff @(posedge clk1mhz or negedge rst_n) begin
        if (!rst_n) begin
            slot_q       <= '0;
            phase_q      <= '0;
            tick_q       <= 1'b0;
            digit_idx_q  <= DIG_LEFT;
            pend_mode_q  <= 1'b0;
            conv_start_q <= 1'b1;  // first conversion runs right after release
            valid_q      <= 1'b0;
            hund_q       <= '0;
            tens_q       <= '0;
            ones_q       <= '0;
            mode_q       <= 1'b0;
            seg_q        <= SEG_BLANK;
            en_q         <= 3'b111;
        end else begin
            slot_q       <= slot_d;
            phase_q      <= phase_d;
            tick_q       <= tick_d;
            digit_idx_q  <= digit_idx_d;
            pend_mode_q  <= pend_mode_d;
            conv_start_q <= conv_start_d;
            valid_q      <= valid_d;
            hund_q       <= hund_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            mode_q       <= mode_d;
            seg_q        <= seg_d;
            en_q         <= en_d;
        end
    end

    assign seg_n      = seg_q;
    assign digit_en_n = en_q;
    assign mode       = mode_q;

endmodule

// File: tb/tb_dht11_display.sv
// Directed bench for dht11_display with REFRESH_DIV=4, ALT_TICKS=6; expected
// segment/enable/mode values are hand-derived per cycle after reset release.
`timescale 1ns/1ps
module tb_dht11_display;

    logic       clk1mhz;
    logic       rst_n;
    logic [7:0] temp;
    logic [7:0] humidity;
    logic [7:0] seg_n;
    logic [2:0] digit_en_n;
    logic       mode;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    dht11_display #(
        .REFRESH_DIV (4),
        .ALT_TICKS   (6)
    ) dut (
        .clk1mhz    (clk1mhz),
        .rst_n      (rst_n),
        .temp       (temp),
        .humidity   (humidity),
        .seg_n      (seg_n),
        .digit_en_n (digit_en_n),
        .mode       (mode)
    );

    initial clk1mhz = 1'b0;
    always #5 clk1mhz = ~clk1mhz;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    // Advance to 1 ns after the k-th rising edge since reset release
    task automatic run_to(input int k);
        while (cyc < k) begin
            @(posedge clk1mhz);
            cyc++;
        end
        #1;
    endtask

    task automatic check_slot(input string tag, input logic [2:0] en, input logic [7:0] seg);
        check({tag, "_en"}, {5'b0, digit_en_n}, {5'b0, en});
        check({tag, "_seg"}, seg_n, seg);
    endtask

    initial begin
        rst_n    = 1'b0;
        temp     = 8'd25;
        humidity = 8'd60;
        #25;
        check("rst_seg", seg_n, 8'hFF);
        check("rst_en", {5'b0, digit_en_n}, 8'h07);
        check("rst_mode", {7'b0, mode}, 8'h00);
        @(negedge clk1mhz);
        rst_n = 1'b1;
        cyc   = 0;

        // Reset release and first (uncommitted) slots
        run_to(4);   check("pre_tick_en", {5'b0, digit_en_n}, 8'h07);
        run_to(5);   check_slot("first", 3'b011, 8'hFF);
        run_to(9);   check_slot("blank_mid", 3'b101, 8'hFF);
                     check("mode_t0", {7'b0, mode}, 8'h00);
        // Temperature 25
        run_to(13);  check_slot("t25_ones", 3'b110, 8'h92);
        run_to(16);  check_slot("t25_hold", 3'b110, 8'h92);
        run_to(17);  check_slot("t25_let", 3'b011, 8'h87);
        run_to(21);  check_slot("t25_tens", 3'b101, 8'hA4);
        run_to(25);  check_slot("t25_ones2", 3'b110, 8'h92);
        // Phase wrap at cycle 25, humidity commit at 35
        run_to(34);  check("mode_pre_h", {7'b0, mode}, 8'h00);
        run_to(35);  check("mode_h", {7'b0, mode}, 8'h01);
        run_to(37);  check_slot("h60_ones", 3'b110, 8'hC0);
        temp = 8'd7;
        run_to(41);  check_slot("h60_let", 3'b011, 8'h89);
        run_to(45);  check_slot("h60_tens", 3'b101, 8'h82);
        // Temperature 7: leading-zero blank
        run_to(58);  check("mode_pre_t", {7'b0, mode}, 8'h01);
        run_to(59);  check("mode_t", {7'b0, mode}, 8'h00);
        run_to(61);  check_slot("t7_ones", 3'b110, 8'hF8);
        humidity = 8'd255;
        run_to(65);  check_slot("t7_let", 3'b011, 8'h87);
        run_to(69);  check_slot("t7_tens", 3'b101, 8'hFF);
        // Humidity 255: overflow dashes
        run_to(83);  check("mode_h2", {7'b0, mode}, 8'h01);
        run_to(85);  check_slot("h255_ones", 3'b110, 8'hBF);
        run_to(89);  check_slot("h255_let", 3'b011, 8'h89);
        temp = 8'd25;
        run_to(93);  check_slot("h255_tens", 3'b101, 8'hBF);
        // Temperature 25 again, then a mid-phase change to 33
        run_to(107); check("mode_t2", {7'b0, mode}, 8'h00);
        run_to(109); check_slot("t25b_ones", 3'b110, 8'h92);
        temp = 8'd33;
        run_to(113); check_slot("t25b_let", 3'b011, 8'h87);
        run_to(117); check_slot("t25b_tens", 3'b101, 8'hA4);
        run_to(121); check_slot("t25b_ones2", 3'b110, 8'h92);
        run_to(129); check_slot("t25b_tens2", 3'b101, 8'hA4);
        run_to(131); check("mode_h3", {7'b0, mode}, 8'h01);
        run_to(157); check_slot("t33_ones", 3'b110, 8'hB0);
        run_to(161); check_slot("t33_let", 3'b011, 8'h87);
        run_to(165); check_slot("t33_tens", 3'b101, 8'hB0);
        run_to(180); check("mode_h4", {7'b0, mode}, 8'h01);

        // Temperature conv_start follows the wrap at 193; reset 4 cycles later
        run_to(197);
        rst_n = 1'b0;
        #1;
        check("mid_rst_seg", seg_n, 8'hFF);
        check("mid_rst_en", {5'b0, digit_en_n}, 8'h07);
        check("mid_rst_mode", {7'b0, mode}, 8'h00);
        @(negedge clk1mhz);
        rst_n = 1'b1;
        cyc   = 0;
        run_to(5);   check_slot("r_first", 3'b011, 8'hFF);
        run_to(9);   check_slot("r_mid", 3'b101, 8'hFF);
        run_to(10);  check("r_mode", {7'b0, mode}, 8'h00);
        run_to(13);  check_slot("r_ones", 3'b110, 8'hB0);
        run_to(17);  check_slot("r_let", 3'b011, 8'h87);
        run_to(21);  check_slot("r_tens", 3'b101, 8'hB0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
